// File: rtl/display_pkg.sv
// Shared constants, state encoding and nibble helper for the four-digit
// multiplexed display scanner.
package display_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam int NIBBLE_W    = 4;
  localparam int WORD_W      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic logic [NIBBLE_W-1:0] digit_of(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
    return word[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/display_scanner_tick_divider.sv
// Dwell counter: counts clock cycles while run is high and flags the last
// cycle of each TICK_DIV-long dwell. Dropping run returns the count to zero.
module tick_divider #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int            DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;

  assign tick = run && (dwell_q == LAST);

  always_comb begin
    dwell_d = '0;
    if (run && !tick) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit display scanner: latches a packed hex word and presents one
// nibble at a time with its digit index, accepting a new word only at pass end.
module display_scanner
  import display_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   wordIn,
  input  logic                wordValid,
  output logic                wordReady,
  input  logic                stop,
  input  logic                clear,
  output logic [NIBBLE_W-1:0] valueOut,
  output logic [1:0]          displaySelect,
  output logic                passDone
);

  localparam logic [1:0] LAST_DIGIT = 2'(DIGIT_COUNT - 1);

  state_e            state_q, state_d;
  logic [1:0]        digit_q, digit_d;
  logic [WORD_W-1:0] word_q,  word_d;

  logic run;
  logic tick;
  logic pass_end;
  logic xfer;

  // clear stops the dwell counter on the same cycle so it restarts from zero.
  assign run      = (state_q == SCAN) && !clear;
  assign pass_end = tick && (digit_q == LAST_DIGIT);
  assign xfer     = wordValid && wordReady;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    wordReady = 1'b0;
    if (!clear) begin
      if (state_q == IDLE) begin
        wordReady = 1'b1;
      end else if (pass_end && !stop) begin
        wordReady = 1'b1;
      end
    end
  end

  assign passDone      = pass_end;
  assign displaySelect = (state_q == SCAN) ? digit_q : 2'd0;
  assign valueOut      = (state_q == SCAN) ? digit_of(word_q, digit_q) : '0;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    word_d  = word_q;
    if (clear) begin
      state_d = IDLE;
      digit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            word_d  = wordIn;
            digit_d = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (tick) begin
            // Digit wraps 3->0 on its own, so a new pass starts at digit 0.
            digit_d = digit_q + 2'd1;
            if (pass_end && stop) begin
              state_d = IDLE;
            end
            if (xfer) begin
              word_d = wordIn;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      digit_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: two instances (TICK_DIV=4 and TICK_DIV=1) share
// stimulus and are compared against a pass-position model every cycle.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wordIn = 16'h0;
  logic        wordValid = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;

  logic [3:0] val4, val1;
  logic [1:0] sel4, sel1;
  logic       rdy4, rdy1, pd4, pd1;

  display_scanner #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(rdy4), .stop(stop), .clear(clear), .valueOut(val4),
    .displaySelect(sel4), .passDone(pd4)
  );

  display_scanner #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(rdy1), .stop(stop), .clear(clear), .valueOut(val1),
    .displaySelect(sel1), .passDone(pd1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int d);
    logic [15:0] sh;
    sh = w >> (4 * d);
    return sh[3:0];
  endfunction

  // Reference model: each scanner is either idle or at position t within a
  // pass of 4*TD cycles; digit = t/TD, pass end = last position.
  logic        m_act [2];
  int unsigned m_t   [2];
  logic [15:0] m_word[2];

  function automatic int unsigned td(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic m_end(input int i);
    return m_act[i] && (m_t[i] == 4 * td(i) - 1);
  endfunction

  function automatic logic m_ready(input int i);
    return !clear && (!m_act[i] || (m_end(i) && !stop));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]  <= 1'b0;
        m_t[i]    <= 0;
        m_word[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          m_act[i] <= 1'b0;
          m_t[i]   <= 0;
        end else if (!m_act[i]) begin
          if (wordValid) begin
            m_act[i]  <= 1'b1;
            m_t[i]    <= 0;
            m_word[i] <= wordIn;
          end
        end else if (m_end(i)) begin
          m_t[i] <= 0;
          if (stop) m_act[i] <= 1'b0;
          else if (wordValid) m_word[i] <= wordIn;
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      int esel, eval, epd, erdy;
      esel = m_act[i] ? int'(m_t[i] / td(i)) : 0;
      eval = m_act[i] ? int'(nib(m_word[i], esel)) : 0;
      epd  = (m_end(i) && !clear) ? 1 : 0;
      erdy = m_ready(i) ? 1 : 0;
      chk($sformatf("model%0d sel", i), int'(i == 0 ? sel4 : sel1), esel);
      chk($sformatf("model%0d val", i), int'(i == 0 ? val4 : val1), eval);
      chk($sformatf("model%0d passDone", i), int'(i == 0 ? pd4 : pd1), epd);
      chk($sformatf("model%0d wordReady", i), int'(i == 0 ? rdy4 : rdy1), erdy);
    end
  endtask

  // One cycle: drive inputs after the edge, check at the falling edge.
  task automatic cyc(input logic v, input logic [15:0] w, input logic s, input logic c);
    @(posedge clk);
    #1;
    wordValid = v;
    wordIn    = w;
    stop      = s;
    clear     = c;
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic        v;
    logic [15:0] w;
    logic [3:0]  val;
    logic [1:0]  sel;
    logic        pd;
    logic        rdy;
  } vec_t;

  vec_t       tbl[18];
  logic [3:0] beef_dig[4];
  logic [31:0] rnd;

  initial begin
    beef_dig[0] = 4'hF; beef_dig[1] = 4'hE; beef_dig[2] = 4'hE; beef_dig[3] = 4'hB;
    tbl[0] = '{v: 1'b1, w: 16'hBEEF, val: 4'h0, sel: 2'd0, pd: 1'b0, rdy: 1'b1};
    for (int k = 0; k < 16; k++)
      tbl[k+1] = '{v: 1'b0, w: 16'h0, val: beef_dig[k/4], sel: 2'(k/4),
                   pd: (k == 15), rdy: (k == 15)};
    tbl[17] = '{v: 1'b0, w: 16'h0, val: 4'hF, sel: 2'd0, pd: 1'b0, rdy: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset val4", int'(val4), 0);
    chk("reset sel4", int'(sel4), 0);
    chk("reset pd4", int'(pd4), 0);
    chk("reset rdy4", int'(rdy4), 1);
    chk("reset rdy1", int'(rdy1), 1);
    check_model();
    rst_n = 1'b1;

    // Basic scan of 0xBEEF with TICK_DIV=4
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, tbl[i].w, 1'b0, 1'b0);
      chk($sformatf("tbl[%0d] val", i), int'(val4), int'(tbl[i].val));
      chk($sformatf("tbl[%0d] sel", i), int'(sel4), int'(tbl[i].sel));
      chk($sformatf("tbl[%0d] passDone", i), int'(pd4), int'(tbl[i].pd));
      chk($sformatf("tbl[%0d] wordReady", i), int'(rdy4), int'(tbl[i].rdy));
    end

    // New word held valid: accepted only at pass end
    for (int k = 1; k < 16; k++) begin
      cyc(1'b1, 16'h1234, 1'b0, 1'b0);
      chk($sformatf("hold k=%0d wordReady", k), int'(rdy4), (k == 15) ? 1 : 0);
    end
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("next pass k=%0d val", k), int'(val4), int'(nib(16'h1234, k / 4)));
      chk($sformatf("next pass k=%0d sel", k), int'(sel4), k / 4);
    end

    // stop held from digit 1, with a word offered
    for (int k = 0; k < 16; k++) begin
      cyc(k >= 4, 16'h9999, k >= 4, 1'b0);
      chk($sformatf("stop k=%0d wordReady", k), int'(rdy4), 0);
      chk($sformatf("stop k=%0d passDone", k), int'(pd4), (k == 15) ? 1 : 0);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("after stop val", int'(val4), 0);
    chk("after stop sel", int'(sel4), 0);
    chk("after stop wordReady", int'(rdy4), 1);

    // clear at digit 2 with a word offered
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h7777, 1'b0, 1'b1);
    chk("clear sel", int'(sel4), 2);
    chk("clear wordReady", int'(rdy4), 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("after clear val", int'(val4), 0);
    chk("after clear wordReady", int'(rdy4), 1);
    cyc(1'b1, 16'h1357, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("restart sel", int'(sel4), 0);
    chk("restart val", int'(val4), 7);

    // Asynchronous reset in the middle of digit 3
    for (int k = 1; k <= 12; k++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre-reset sel", int'(sel4), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset val", int'(val4), 0);
    chk("async reset sel", int'(sel4), 0);
    chk("async reset passDone", int'(pd4), 0);
    chk("async reset wordReady", int'(rdy4), 1);
    check_model();
    @(posedge clk);
    #1;
    chk("held reset passDone", int'(pd4), 0);
    rst_n = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("post reset wordReady", int'(rdy4), 1);

    // TICK_DIV=1: one digit per cycle
    cyc(1'b1, 16'hA5C3, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("td1 k=%0d val", k), int'(val1), int'(nib(16'hA5C3, k % 4)));
      chk($sformatf("td1 k=%0d passDone", k), int'(pd1), (k % 4 == 3) ? 1 : 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      cyc($urandom_range(0, 3) != 0, rnd[15:0],
          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
